bram_rd_ctrl: RTL

Read-side controller for the single-port block RAM used by the image labs. On a `start` command it issues a burst of sequential word reads from the BRAM, absorbs the RAM's one-cycle registered read latency, and presents the words downstream on a valid/ready stream with full backpressure. It sits directly between the BRAM and the next processing stage (e.g. a pixel pipeline), and is the only master of the BRAM port while `busy` is high.

---
 rtl/bram_rd_ctrl_pkg.sv | 19 +
 rtl/bram_rd_ctrl_if.sv | 30 +++
 rtl/bram_rd_ctrl_fifo.sv | 58 +++++
 rtl/bram_rd_ctrl.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/bram_rd_ctrl_pkg.sv
// Shared types and constants for the BRAM read controller.
package bram_ctrl_pkg;

  // Controller states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Output FIFO depth and the matching occupancy counter width (0..DEPTH)
  localparam int FIFO_DEPTH = 4;
  localparam int W_FCNT     = $clog2(FIFO_DEPTH) + 1;

  // Reads may be issued only while FIFO words plus in-flight reads stay below this
  localparam logic [W_FCNT:0] CREDIT_LIMIT = (W_FCNT + 1)'(FIFO_DEPTH);

endpackage

// File: rtl/bram_rd_ctrl_if.sv
// Command, BRAM port and output stream signals of the BRAM read controller.
// The master modport is the controller's view; slave is the environment's view.
interface bram_rd_ctrl_if #(
  parameter int W_DATA = 32,
  parameter int W_WORD = 4
);
  logic              start;
  logic [W_WORD-1:0] start_addr;
  logic [W_WORD:0]   num_words;
  logic              busy;
  logic              done;
  logic              bram_en;
  logic              bram_we;
  logic [W_WORD-1:0] bram_addr;
  logic [W_DATA-1:0] bram_dout;
  logic              m_valid;
  logic              m_ready;
  logic [W_DATA-1:0] m_data;
  logic              m_last;

  modport master (
    input  start, start_addr, num_words, bram_dout, m_ready,
    output busy, done, bram_en, bram_we, bram_addr, m_valid, m_data, m_last
  );

  modport slave (
    output start, start_addr, num_words, bram_dout, m_ready,
    input  busy, done, bram_en, bram_we, bram_addr, m_valid, m_data, m_last
  );
endinterface

// File: rtl/bram_rd_ctrl_fifo.sv
// Small synchronous FIFO holding read words (with their last flag) between
// the BRAM and the output stream. Storage is cleared on reset so the
// head data reads back as zero.
module rd_ctrl_fifo
  import bram_ctrl_pkg::*;
#(
  parameter int W_DATA = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_push,
  input  logic [W_DATA-1:0] i_data,
  input  logic              i_last,
  input  logic              i_pop,
  output logic [W_DATA-1:0] o_data,
  output logic              o_last,
  output logic              o_empty,
  output logic [W_FCNT-1:0] o_count
);
  localparam int W_PTR = $clog2(FIFO_DEPTH);
  localparam logic [W_FCNT-1:0] FULL_CNT = W_FCNT'(FIFO_DEPTH);

  logic [W_DATA-1:0]     r_mem [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] r_last;
  logic [W_PTR-1:0]      r_wr_ptr;
  logic [W_PTR-1:0]      r_rd_ptr;
  logic [W_FCNT-1:0]     r_count;
  logic                  w_push;
  logic                  w_pop;

  assign w_push = i_push && (r_count != FULL_CNT);
  assign w_pop  = i_pop && (r_count != '0);

  // Storage, pointers and occupancy
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
      r_last   <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr]  <= i_data;
        r_last[r_wr_ptr] <= i_last;
        r_wr_ptr         <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + W_FCNT'(w_push) - W_FCNT'(w_pop);
    end
  end

  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_data  = r_mem[r_rd_ptr];
  assign o_last  = r_last[r_rd_ptr] & ~o_empty;

endmodule

// File: rtl/bram_rd_ctrl.sv
// Burst read controller for a single-port BRAM with one-cycle registered
// read latency. Reads are paced by a credit check so that every issued read
// has a guaranteed FIFO slot, giving full backpressure on the output stream.
// Optional feature macro: BRAM_RD_CTRL_LAST_EN enables m_last generation;
// when undefined m_last is constant 0.
//
// state | meaning
// IDLE  | waiting for start
// READ  | issuing reads while credit allows
// DRAIN | all reads issued, emptying FIFO downstream
// DONE  | one-cycle done pulse
module bram_rd_ctrl
  import bram_ctrl_pkg::*;
#(
  parameter int W_DATA = 32,
  parameter int N_WORD = 16,
  parameter int W_WORD = 4
) (
  input  logic            clk,
  input  logic            rst,
  bram_rd_ctrl_if.master  bus
);
  state_t            r_state;
  state_t            w_state_nxt;
  logic [W_WORD-1:0] r_addr;
  logic [W_WORD:0]   r_num;
  logic [W_WORD:0]   r_issue_cnt;
  logic [W_WORD:0]   r_out_cnt;
  logic [1:0]        r_inflight;
  logic              r_rd_vld;
  logic              r_rd_last;

  logic              w_busy;
  logic              w_done;
  logic              w_issue;
  logic              w_last_issue;
  logic              w_hs;
  logic              w_credit;
  logic [W_FCNT:0]   w_used;
  logic [W_DATA-1:0] w_fifo_data;
  logic              w_fifo_last;
  logic              w_fifo_empty;
  logic [W_FCNT-1:0] w_fifo_count;

  assign w_used   = (W_FCNT + 1)'(w_fifo_count) + (W_FCNT + 1)'(r_inflight);
  assign w_credit = (w_used < CREDIT_LIMIT);
  assign w_issue  = (r_state == READ) && (r_issue_cnt != r_num) && w_credit;
  assign w_hs     = ~w_fifo_empty & bus.m_ready;

`ifdef BRAM_RD_CTRL_LAST_EN
  assign w_last_issue = (r_issue_cnt == r_num - 1'b1);
`else
  assign w_last_issue = 1'b0;
`endif

  // State register and burst bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_addr      <= '0;
      r_num       <= '0;
      r_issue_cnt <= '0;
      r_out_cnt   <= '0;
      r_inflight  <= '0;
      r_rd_vld    <= 1'b0;
      r_rd_last   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if ((r_state == IDLE) && bus.start) begin
        r_addr      <= bus.start_addr;
        r_num       <= bus.num_words;
        r_issue_cnt <= '0;
        r_out_cnt   <= '0;
      end
      if (w_issue) begin
        r_addr      <= (r_addr == W_WORD'(N_WORD - 1)) ? '0 : r_addr + 1'b1;
        r_issue_cnt <= r_issue_cnt + 1'b1;
      end
      if (w_hs) r_out_cnt <= r_out_cnt + 1'b1;
      // BRAM data for a read issued this cycle is on bram_dout next cycle
      r_rd_vld  <= w_issue;
      r_rd_last <= w_issue & w_last_issue;
      case ({w_issue, r_rd_vld})
        2'b10:   r_inflight <= r_inflight + 1'b1;
        2'b01:   r_inflight <= r_inflight - 1'b1;
        default: r_inflight <= r_inflight;
      endcase
    end
  end

  // Next-state and status outputs
  always_comb begin
    w_state_nxt = r_state;
    w_busy      = 1'b1;
    w_done      = 1'b0;
    case (r_state)
      IDLE: begin
        w_busy = 1'b0;
        if (bus.start) w_state_nxt = (bus.num_words == '0) ? DONE : READ;
      end
      READ: begin
        if (w_issue && (r_issue_cnt == r_num - 1'b1)) w_state_nxt = DRAIN;
      end
      DRAIN: begin
        if (w_hs && (r_out_cnt == r_num - 1'b1)) w_state_nxt = DONE;
      end
      DONE: begin
        w_done      = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  rd_ctrl_fifo #(
    .W_DATA (W_DATA)
  ) u_fifo (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_push  (r_rd_vld),
    .i_data  (bus.bram_dout),
    .i_last  (r_rd_last),
    .i_pop   (w_hs),
    .o_data  (w_fifo_data),
    .o_last  (w_fifo_last),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_count)
  );

  assign bus.busy      = w_busy;
  assign bus.done      = w_done;
  assign bus.bram_en   = w_issue;
  assign bus.bram_we   = 1'b0;
  assign bus.bram_addr = w_issue ? r_addr : '0;
  assign bus.m_valid   = ~w_fifo_empty;
  assign bus.m_data    = w_fifo_data;
  // Last flags are only ever written as 1 when the feature is enabled
  assign bus.m_last    = w_fifo_last;

endmodule
